// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes, functs, ALU opCodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_BNE     = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam int unsigned NUM_STATES = 13;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        FUNCT = 2'd2,
        IMM   = 2'd3
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic funct_supported(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_NOR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the control FSM and the multicycle datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath always accepts control.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [3:0] alu_ctrl;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, zero,
        output ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, imm_zext, pc_src, alu_ctrl, illegal_op, state_o
    );

    modport slave (
        output opcode, funct, zero,
        input  ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, imm_zext, pc_src, alu_ctrl, illegal_op, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU opCode decoder shared by the multicycle and future pipelined cores.
// Latency: combinational.
// Backpressure: none.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ADD: alu_ctrl = ALU_ADD;
            SUB: alu_ctrl = ALU_SUB;
            FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            IMM: begin
                case (opcode)
                    OP_ADDI: alu_ctrl = ALU_ADD;
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath; drives every mux/enable and the ALU opCode.
// Latency: Moore outputs per state; lw 5, sw/R/imm 4, beq/bne/j 3 cycles.
// Backpressure: none; reset drops all write enables asynchronously.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit RESET_STATE_ONEHOT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctrl_if.master  bus
);

    state_t  state;
    state_t  state_d;
    logic    illegal_q, illegal_d;

    logic    ir_write_c, pc_write_c, pc_en_c, iord_c, mem_write_c, reg_write_c;
    logic    reg_dst_c, mem_to_reg_c, alu_src_a_c, imm_zext_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    alu_op_t alu_op_c;

    generate
        if (RESET_STATE_ONEHOT) begin : g_onehot
            logic [NUM_STATES-1:0] oh_q, oh_d;

            assign oh_d = NUM_STATES'(1) << state_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) oh_q <= NUM_STATES'(1);
                else        oh_q <= oh_d;
            end

            // Anything that is not exactly one-hot decodes as FETCH.
            always_comb begin
                state = S_FETCH;
                if ($onehot(oh_q)) begin
                    for (int i = 0; i < NUM_STATES; i++) begin
                        if (oh_q[i]) state = state_t'(4'(i));
                    end
                end
            end
        end else begin : g_binary
            logic [3:0] bin_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) bin_q <= S_FETCH;
                else        bin_q <= state_d;
            end

            assign state = state_t'(bin_q);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        illegal_d    = illegal_q;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_en_c      = 1'b0;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        imm_zext_c   = 1'b0;
        pc_src_c     = 2'b00;
        alu_op_c     = ADD;

        case (state)
            S_FETCH: begin
                ir_write_c  = 1'b1;
                alu_src_b_c = 2'b01;
                pc_write_c  = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ:                           state_d = S_BEQ;
                    OP_BNE:                           state_d = S_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
                    OP_J:                             state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_supported(bus.funct)) state_d = S_EXECUTE;
                        else                            illegal_d = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
            end
            S_MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = SUB;
                pc_src_c    = 2'b01;
                pc_en_c     = (state == S_BEQ) ? bus.zero : ~bus.zero;
            end
            S_IMMEXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = IMM;
                imm_zext_c  = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_c = 1'b1;
            end
            S_JUMP: begin
                pc_src_c   = 2'b10;
                pc_write_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .alu_op   (alu_op_c),
        .funct    (bus.funct),
        .opcode   (bus.opcode),
        .alu_ctrl (bus.alu_ctrl)
    );

    // Enables are gated by rst_n so they fall in the same cycle reset asserts.
    assign bus.ir_write   = ir_write_c  & rst_n;
    assign bus.pc_en      = (pc_write_c | pc_en_c) & rst_n;
    assign bus.mem_write  = mem_write_c & rst_n;
    assign bus.reg_write  = reg_write_c & rst_n;
    assign bus.iord       = iord_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.imm_zext   = imm_zext_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.illegal_op = illegal_q;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction step model, directed pins, random instruction stream.
module tb_mips_multicycle_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.RESET_STATE_ONEHOT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ir_write, pc_en, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [3:0] alu_ctrl;
        logic       alu_chk;
    } exp_t;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic       chk_en = 1'b0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;
    int         step   = 0;
    logic       model_ill = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (op=%b fn=%b step=%0d t=%0t)",
                      name, act, exp, cur_op, cur_fn, step, $time);
    endtask

    function automatic logic fn_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 bne, 5 imm, 6 j, 7 illegal
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return fn_ok(fn) ? 0 : 7;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b000101: return 4;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return 5;
            6'b000010: return 6;
            default:   return 7;
        endcase
    endfunction

    function automatic int len_of(input int k);
        case (k)
            1:       return 5;
            0, 2, 5: return 4;
            3, 4, 6: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_fn(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1100;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_imm(input logic [5:0] op);
        case (op)
            6'b001100: return 4'b0000;
            6'b001101: return 4'b0001;
            6'b001010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int s, input logic z);
        exp_t e;
        int   k;
        e = '0;
        k = kind_of(op, fn);
        if (s == 0) begin
            e.ir_write = 1'b1; e.pc_en = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 4'b0010; e.alu_chk = 1'b1;
        end else if (s == 1) begin
            e.alu_src_b = 2'b11; e.alu_ctrl = 4'b0010; e.alu_chk = 1'b1;
        end else begin
            case (k)
                0: if (s == 2) begin
                       e.alu_src_a = 1'b1; e.alu_ctrl = alu_of_fn(fn); e.alu_chk = 1'b1;
                   end else begin
                       e.reg_write = 1'b1; e.reg_dst = 1'b1;
                   end
                1, 2: if (s == 2) begin
                       e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 4'b0010; e.alu_chk = 1'b1;
                   end else if (s == 3) begin
                       e.iord = 1'b1; e.mem_write = (k == 2);
                   end else begin
                       e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                   end
                3, 4: begin
                       e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0110; e.alu_chk = 1'b1; e.pc_src = 2'b01;
                       e.pc_en = (k == 3) ? z : ~z;
                   end
                5: if (s == 2) begin
                       e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = alu_of_imm(op); e.alu_chk = 1'b1;
                       e.imm_zext = (op == 6'b001100) || (op == 6'b001101);
                   end else begin
                       e.reg_write = 1'b1;
                   end
                6: begin
                       e.pc_src = 2'b10; e.pc_en = 1'b1;
                   end
                default: ;
            endcase
        end
        return e;
    endfunction

    exp_t ce;
    always @(negedge clk) begin
        if (chk_en) begin
            ce = model(cur_op, cur_fn, step, bus.zero);
            chk("ir_write",   4'(bus.ir_write),   4'(ce.ir_write));
            chk("pc_en",      4'(bus.pc_en),      4'(ce.pc_en));
            chk("iord",       4'(bus.iord),       4'(ce.iord));
            chk("mem_write",  4'(bus.mem_write),  4'(ce.mem_write));
            chk("reg_write",  4'(bus.reg_write),  4'(ce.reg_write));
            chk("reg_dst",    4'(bus.reg_dst),    4'(ce.reg_dst));
            chk("mem_to_reg", 4'(bus.mem_to_reg), 4'(ce.mem_to_reg));
            chk("alu_src_a",  4'(bus.alu_src_a),  4'(ce.alu_src_a));
            chk("alu_src_b",  4'(bus.alu_src_b),  4'(ce.alu_src_b));
            chk("imm_zext",   4'(bus.imm_zext),   4'(ce.imm_zext));
            chk("pc_src",     4'(bus.pc_src),     4'(ce.pc_src));
            chk("illegal_op", 4'(bus.illegal_op), 4'(model_ill));
            if (ce.alu_chk) chk("alu_ctrl", bus.alu_ctrl, ce.alu_ctrl);
        end
    end

    // zf < 0 randomizes zero every cycle; pstep >= 0 adds literal pins at that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zf,
                             input int pstep, input int palu, input int ppc);
        int k, n;
        cur_op = op; cur_fn = fn;
        bus.opcode = op; bus.funct = fn;
        k = kind_of(op, fn);
        n = len_of(k);
        for (int s = 0; s < n; s++) begin
            step = s;
            bus.zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            if (s == pstep) begin
                #2;
                if (palu >= 0) chk("pin_alu_ctrl", bus.alu_ctrl, 4'(palu));
                if (ppc >= 0)  chk("pin_pc_en", 4'(bus.pc_en), 4'(ppc));
            end
            @(posedge clk); #1;
            if (s == 1 && k == 7) model_ill = 1'b1;
        end
    endtask

    logic [5:0] op_tab [12] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b111111};
    logic [5:0] fn_tab [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] op, fn;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        #12;
        chk("rst_ir_write",   4'(bus.ir_write),   4'd0);
        chk("rst_pc_en",      4'(bus.pc_en),      4'd0);
        chk("rst_illegal_op", 4'(bus.illegal_op), 4'd0);
        chk("rst_alu_ctrl",   bus.alu_ctrl,       4'b0010);
        chk("rst_alu_src_b",  4'(bus.alu_src_b),  4'b0001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step = 0;
        chk_en = 1'b1;

        run_instr(6'b100011, 6'b000000, -1, 2, 4'b0010, -1);  // lw
        run_instr(6'b000000, 6'b101010, -1, 2, 4'b0111, -1);  // slt
        run_instr(6'b000000, 6'b100111, -1, 2, 4'b1100, -1);  // nor
        run_instr(6'b000100, 6'b000000,  1, 2, 4'b0110,  1);  // beq taken
        run_instr(6'b000101, 6'b000000,  1, 2, 4'b0110,  0);  // bne not taken
        run_instr(6'b000101, 6'b000000,  0, 2, 4'b0110,  1);  // bne taken
        run_instr(6'b001101, 6'b000000, -1, 2, 4'b0001, -1);  // ori
        run_instr(6'b000010, 6'b000000, -1, 2, -1,       1);  // j
        run_instr(6'b111111, 6'b000000, -1, -1, -1, -1);
        chk("pin_illegal_set", 4'(bus.illegal_op), 4'd1);
        run_instr(6'b000000, 6'b000000, -1, -1, -1, -1);
        chk("pin_illegal_sticky", 4'(bus.illegal_op), 4'd1);

        for (int i = 0; i < 300; i++) begin
            op = op_tab[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom);
            run_instr(op, fn, -1, -1, -1, -1);
        end

        // Interrupt a sw in MEMWR with reset.
        cur_op = 6'b101011; cur_fn = 6'd0;
        bus.opcode = cur_op; bus.funct = cur_fn;
        for (int s = 0; s < 3; s++) begin
            step = s;
            @(posedge clk); #1;
        end
        step = 3;
        #1;
        chk("pin_memwr_active", 4'(bus.mem_write), 4'd1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_write", 4'(bus.mem_write),  4'd0);
        chk("rst_mid_ir_write",  4'(bus.ir_write),   4'd0);
        chk("rst_mid_pc_en",     4'(bus.pc_en),      4'd0);
        chk("rst_mid_reg_write", 4'(bus.reg_write),  4'd0);
        chk("rst_mid_illegal",   4'(bus.illegal_op), 4'd0);
        model_ill = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_ir_write", 4'(bus.ir_write), 4'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ir_write", 4'(bus.ir_write), 4'd1);
        chk("rel_pc_en",    4'(bus.pc_en),    4'd1);
        chk("rel_alu_ctrl", bus.alu_ctrl,     4'b0010);
        step = 0;
        chk_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            op = op_tab[$urandom_range(2, 10)];
            fn = fn_tab[$urandom_range(0, 5)];
            run_instr(op, fn, -1, -1, -1, -1);
        end
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives every datapath mux and enable. It also drives the 4-bit ALU opCode through an embedded ALU decoder, so it sits directly upstream of the ALU. It consumes the ALU zero flag to resolve branches.

Parameters:
RESET_STATE_ONEHOT, 0, 0 = binary state encoding; 1 = one-hot encoding. Observable behaviour is identical for both values.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
ir_write  output  1  load instruction register
pc_en  output  1  load PC (pc_write | branch-taken)
iord  output  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  output  1  data memory write enable
reg_write  output  1  register file write enable
reg_dst  output  1  write register: 0 = rt, 1 = rd
mem_to_reg  output  1  writeback data: 0 = ALUOut, 1 = memory data
alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
imm_zext  output  1  select zero-extension of the immediate (andi/ori)
pc_src  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_ctrl  output  4  ALU opCode
illegal_op  output  1  sticky flag: an unsupported instruction was decoded
state_o  output  4  current state, debug only

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous, active-low.
- While rst_n = 0:
  - state = FETCH; illegal_op = 0.
  - ir_write, pc_en, mem_write and reg_write are forced to 0.
  - All other outputs hold their FETCH values.
- The first rising edge after reset release executes FETCH.
- Outputs are Moore outputs (a function of state only), with one exception: pc_en also depends on zero in the branch states.
- States and transitions:
  - FETCH -> DECODE. Outputs: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00, pc_write=1.
  - DECODE (alu_src_a=0, alu_src_b=11, alu_op=ADD; precomputes branch target). Next state by opcode:
    - lw/sw -> MEMADR
    - R-type with supported funct -> EXECUTE
    - beq -> BEQ; bne -> BNE
    - addi/andi/ori/slti -> IMMEXEC
    - j -> JUMP
    - anything else -> FETCH, and set illegal_op on that edge.
  - MEMADR (alu_src_a=1, alu_src_b=10, ADD) -> MEMRD if lw, MEMWR if sw.
  - MEMRD (iord=1) -> MEMWB.
  - MEMWB (reg_dst=0, mem_to_reg=1, reg_write=1) -> FETCH.
  - MEMWR (iord=1, mem_write=1) -> FETCH.
  - EXECUTE (alu_src_a=1, alu_src_b=00, alu_op=FUNCT) -> ALUWB.
  - ALUWB (reg_dst=1, mem_to_reg=0, reg_write=1) -> FETCH.
  - BEQ and BNE (alu_src_a=1, alu_src_b=00, SUB, pc_src=01) -> FETCH.
    - BEQ: pc_en = zero. BNE: pc_en = ~zero.
  - IMMEXEC (alu_src_a=1, alu_src_b=10, alu_op=IMM, imm_zext=1 for andi/ori) -> IMMWB.
  - IMMWB (reg_dst=0, mem_to_reg=0, reg_write=1) -> FETCH.
  - JUMP (pc_src=10, pc_write=1) -> FETCH.
  - Any unreachable state encoding -> FETCH.
- Outputs not listed for a state are 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, slti=001010, j=000010.
- ALU decode (combinational, from alu_op, funct, opcode):
  - ADD -> 0010; SUB -> 0110.
  - FUNCT: add 100000 -> 0010, sub 100010 -> 0110, and 100100 -> 0000, or 100101 -> 0001, slt 101010 -> 0111, nor 100111 -> 1100.
  - IMM: addi -> 0010, andi -> 0000, ori -> 0001, slti -> 0111.
- An R-type with unsupported funct is handled as an illegal instruction: DECODE -> FETCH, illegal_op set, no register write.
- illegal_op is cleared only by reset.
- Cycle counts: lw 5, sw 4, R-type 4, imm 4, beq/bne 3, j 3.
- Reset mid-instruction: all enables drop asynchronously in the same cycle; the partially executed instruction is abandoned.

Decomposition:
- Package mips_pkg contains:
  - state_t enum
  - opcode and funct localparams
  - ALU opCode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR)
  - alu_op_t enum {ADD, SUB, FUNCT, IMM}
- Sub-module mips_alu_decoder: purely combinational; inputs alu_op, funct, opcode; output alu_ctrl. It is shared with a future pipelined core.

Test Plan:
- Reset held low during MEMWR (mem_write=1) -> mem_write drops to 0 immediately; after release, FETCH with ir_write=1, pc_en=1, alu_ctrl=0010.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 with mem_to_reg=1 only in MEMWB; iord=1 in MEMRD.
- R-type funct 101010 -> alu_ctrl=0111 in EXECUTE; reg_write=1 with reg_dst=1 in ALUWB. Repeat for funct 100111 -> alu_ctrl=1100.
- beq with zero=1 -> pc_en=1, pc_src=01 in BEQ. bne with zero=1 -> pc_en=0. bne with zero=0 -> pc_en=1.
- ori (001101) -> IMMEXEC shows alu_ctrl=0001, imm_zext=1, alu_src_b=10; IMMWB shows reg_write=1, reg_dst=0.
- opcode 111111, then R-type funct 000000 -> each returns DECODE -> FETCH with no reg_write or mem_write; illegal_op goes to 1 and stays 1 until rst_n is asserted.
